// File: rtl/blft_pkg.sv
// blft_pkg: shared constants, state encoding and border predicate for the bilateral-filter write-back stage
package blft_pkg;
  localparam int IMG_DIM = 256;
  localparam int MARGIN = 5;
  localparam int ADDR_W = 16;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {RUN, BORDER, DONE} state_e;
  function automatic logic is_border(input logic [7:0] row, input logic [7:0] col);
    return row < 8'(MARGIN) || row > 8'(IMG_DIM-1-MARGIN) || col < 8'(MARGIN) || col > 8'(IMG_DIM-1-MARGIN);
  endfunction
endpackage

// File: rtl/blft_wb_fifo.sv
// blft_wb_fifo: single-clock FIFO with full/empty flags and simultaneous push/pop
module blft_wb_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/blft_wb.sv
// blft_wb: buffers filtered pixels, drains them to SRAM, then fills the image border and raises done.
// Optional BLFT_WB_CHECKSUM_EN adds chk_sum, a 24-bit sum of all completed write data.
module blft_wb import blft_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter logic [PIX_W-1:0] BORDER_VAL = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_finish,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              overflow,
  output logic [16:0]       pix_cnt,
  output logic              done
`ifdef BLFT_WB_CHECKSUM_EN
  , output logic [23:0]     chk_sum
`endif
);
  state_e state_q, state_d;
  logic wen_q, wen_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0] wdata_q, wdata_d;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0] row_q, row_d, col_q, col_d, row_nx, col_nx;
  logic push, pop, full, empty, complete, last;
  logic [ADDR_W+PIX_W-1:0] fifo_dout;
  assign complete = wen_q && mem_ready;
  assign pop = state_q == RUN && !empty && (!wen_q || mem_ready);
  assign push = state_q == RUN && in_valid && (!full || pop);
  assign last = row_q == 8'(IMG_DIM-1) && col_q == 8'(IMG_DIM-1);
  assign row_nx = col_q == 8'(IMG_DIM-1) ? row_q + 8'd1 : row_q;
  // interior rows jump straight from the left margin to the right margin
  assign col_nx = col_q == 8'(IMG_DIM-1) ? 8'd0 : is_border(row_q, col_q + 8'd1) ? col_q + 8'd1 : 8'(IMG_DIM-MARGIN);
  blft_wb_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W+PIX_W)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop),
    .din_i({in_addr, in_data}), .dout_o(fifo_dout), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    wen_d = wen_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    row_d = row_q;
    col_d = col_q;
    ovf_d = ovf_q || (in_valid && !push);
    cnt_d = complete && !cnt_q[16] ? cnt_q + 17'd1 : cnt_q;
    if (state_q == RUN) begin
      wen_d = pop || (wen_q && !mem_ready);
      addr_d = pop ? fifo_dout[ADDR_W+PIX_W-1:PIX_W] : addr_q;
      wdata_d = pop ? fifo_dout[PIX_W-1:0] : wdata_q;
      if (in_finish && !in_valid && empty && !wen_q) begin
        state_d = BORDER;
        wen_d = 1'b1;
        addr_d = {row_q, col_q};
        wdata_d = BORDER_VAL;
      end
    end else if (state_q == BORDER && complete) begin
      state_d = last ? DONE : BORDER;
      wen_d = !last;
      row_d = last ? row_q : row_nx;
      col_d = last ? col_q : col_nx;
      addr_d = last ? addr_q : {row_nx, col_nx};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wen_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end
`ifdef BLFT_WB_CHECKSUM_EN
  logic [23:0] sum_q;
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else if (complete) sum_q <= sum_q + 24'(wdata_q);
  end
  assign chk_sum = sum_q;
`endif
  assign mem_wen = wen_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign overflow = ovf_q;
  assign pix_cnt = cnt_q;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_blft_wb.sv
// tb_blft_wb: randomized self-checking bench for blft_wb against a write-list reference model
module tb_blft_wb;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_finish = 1'b0, mem_ready = 1'b0;
  logic [15:0] in_addr = '0;
  logic [7:0] in_data = '0;
  logic mem_wen, overflow, done;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [16:0] pix_cnt;
`ifdef BLFT_WB_CHECKSUM_EN
  logic [23:0] chk_sum;
`endif
  int checks = 0, errors = 0, hold_viol = 0;
  logic [23:0] got_q[$], exp_q[$];
  logic prev_stall = 1'b0;
  logic [23:0] prev_w = '0;

  blft_wb dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_finish(in_finish), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .overflow(overflow), .pix_cnt(pix_cnt), .done(done)
`ifdef BLFT_WB_CHECKSUM_EN
    , .chk_sum(chk_sum)
`endif
  );

  always #5 clk = ~clk;

  // records completed writes and any change of a stalled request
  always @(negedge clk) begin
    if (prev_stall && (!mem_wen || {mem_addr, mem_wdata} !== prev_w)) hold_viol++;
    prev_stall = !rst && mem_wen && !mem_ready;
    prev_w = {mem_addr, mem_wdata};
    if (!rst && mem_wen && mem_ready) got_q.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_finish = 1'b0;
    tick();
    tick();
    got_q.delete();
    exp_q.delete();
    hold_viol = 0;
    rst = 1'b0;
  endtask

  function automatic void add_border();
    for (int r = 0; r < 256; r++)
      for (int c = 0; c < 256; c++)
        if (r < 5 || r > 250 || c < 5 || c > 250) exp_q.push_back({8'(r), 8'(c), 8'h00});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_addr = 16'h1234;
    in_data = 8'h56;
    mem_ready = 1'b1;
    tick();
    tick();
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", mem_wen); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (pix_cnt !== 17'd0) begin errors++; $display("FAIL reset_pix_cnt: got %0d want 0", pix_cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef BLFT_WB_CHECKSUM_EN
    checks++; if (chk_sum !== 24'h0) begin errors++; $display("FAIL reset_chk_sum: got %h want 0", chk_sum); end
`endif
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    mem_ready = 1'b1;
    in_valid = 1'b1;
    in_addr = 16'h0505;
    in_data = 8'h80;
    tick();
    in_valid = 1'b0;
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL single_early: mem_wen got %b want 0 one cycle after push", mem_wen); end
    tick();
    checks++; if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 16'h0505, 8'h80})
      begin errors++; $display("FAIL single_req: got wen=%b addr=%h data=%h want 1/0505/80", mem_wen, mem_addr, mem_wdata); end
    tick();
    checks++; if (pix_cnt !== 17'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", pix_cnt); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL single_idle: mem_wen got %b want 0", mem_wen); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 24'h050580)
      begin errors++; $display("FAIL single_write: got %0d writes, first %h, want 1 write 050580", got_q.size(), got_q.size() > 0 ? got_q[0] : 24'h0); end
  endtask

  task automatic test_stall();
    logic [23:0] d;
    int bad;
    do_reset();
    mem_ready = 1'b0;
    // register takes the first pixel, FIFO the next 16, the rest are dropped
    for (int i = 0; i < 20; i++) begin
      d = {16'($urandom), 8'($urandom)};
      in_valid = 1'b1;
      {in_addr, in_data} = d;
      if (i < 17) exp_q.push_back(d);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (mem_wen !== 1'b1 || {mem_addr, mem_wdata} !== exp_q[0])
        begin errors++; $display("FAIL stall_hold: got wen=%b %h%h want 1 %h", mem_wen, mem_addr, mem_wdata, exp_q[0]); end
      tick();
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow: got %b want 1", overflow); end
    checks++; if (pix_cnt !== 17'd0) begin errors++; $display("FAIL stall_cnt0: got %0d want 0", pix_cnt); end
    mem_ready = 1'b1;
    for (int i = 0; i < 60 && pix_cnt != 17'd17; i++) tick();
    tick();
    tick();
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++; if (got_q.size() != exp_q.size() || bad >= 0)
      begin errors++; $display("FAIL stall_seq: got %0d writes (first bad index %0d) want %0d in push order", got_q.size(), bad, exp_q.size()); end
    checks++; if (pix_cnt !== 17'd17) begin errors++; $display("FAIL stall_cnt: got %0d want 17", pix_cnt); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_stable: %0d changes while stalled, want 0", hold_viol); end
  endtask

  task automatic test_random_ready();
    logic [23:0] src[$];
    int idx, bad;
    do_reset();
    for (int i = 0; i < 300; i++) src.push_back({8'(5 + i / 246), 8'(5 + i % 246), 8'($urandom)});
    foreach (src[i]) exp_q.push_back(src[i]);
    add_border();
    idx = 0;
    while (idx < 300) begin
      mem_ready = 1'($urandom);
      in_valid = $urandom_range(3) == 0;
      if (in_valid) begin
        {in_addr, in_data} = src[idx];
        idx++;
      end
      tick();
    end
    in_valid = 1'b0;
    in_finish = 1'b1;
    for (int i = 0; i < 20000 && !done; i++) begin
      mem_ready = 1'($urandom);
      tick();
    end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand_done: got %b want 1 within budget", done); end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++; if (got_q.size() != exp_q.size() || bad >= 0)
      begin errors++; $display("FAIL rand_seq: got %0d writes (first bad index %0d) want %0d", got_q.size(), bad, exp_q.size()); end
    checks++; if (pix_cnt !== 17'd5320) begin errors++; $display("FAIL rand_cnt: got %0d want 5320", pix_cnt); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rand_stable: %0d changes while stalled, want 0", hold_viol); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b want 0", overflow); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rand_wen_done: got %b want 0", mem_wen); end
  endtask

  task automatic test_reset_border();
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      {in_addr, in_data} = {8'd5, 8'(5 + i), 8'($urandom)};
      tick();
    end
    in_valid = 1'b0;
    in_finish = 1'b1;
    for (int i = 0; i < 1000 && pix_cnt < 17'd250; i++) tick();
    checks++; if (pix_cnt !== 17'd250 || done !== 1'b0)
      begin errors++; $display("FAIL rb_progress: got cnt=%0d done=%b want 250/0", pix_cnt, done); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rb_violation: overflow got %b want 1 after in_valid in border", overflow); end
    rst = 1'b1;
    in_finish = 1'b0;
    tick();
    checks++; if ({mem_wen, mem_addr, mem_wdata, overflow, pix_cnt, done} !== '0)
      begin errors++; $display("FAIL rb_reset: got wen=%b addr=%h data=%h ovf=%b cnt=%0d done=%b want all 0", mem_wen, mem_addr, mem_wdata, overflow, pix_cnt, done); end
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (mem_wen !== 1'b0 || pix_cnt !== 17'd0)
      begin errors++; $display("FAIL rb_restart: got wen=%b cnt=%0d want idle 0/0", mem_wen, pix_cnt); end
  endtask

  task automatic test_full();
    logic [23:0] d, sum;
    int bad;
    do_reset();
    mem_ready = 1'b1;
    for (int r = 5; r <= 250; r++)
      for (int c = 5; c <= 250; c++) begin
        d = {8'(r), 8'(c), 8'($urandom)};
        exp_q.push_back(d);
        in_valid = 1'b1;
        {in_addr, in_data} = d;
        tick();
      end
    in_valid = 1'b0;
    in_finish = 1'b1;
    add_border();
    for (int i = 0; i < 8000 && !done; i++) tick();
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1 within budget", done); end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++; if (got_q.size() != exp_q.size() || bad >= 0)
      begin errors++; $display("FAIL full_seq: got %0d writes (first bad index %0d) want %0d", got_q.size(), bad, exp_q.size()); end
    checks++; if (got_q.size() <= 60516 || got_q[60516][23:8] !== 16'h0000)
      begin errors++; $display("FAIL full_first_border: got %0d writes, addr %h want 0000", got_q.size(), got_q.size() > 60516 ? got_q[60516][23:8] : 16'hxxxx); end
    checks++; if (got_q.size() != 65536 || got_q[65535][23:8] !== 16'hFFFF)
      begin errors++; $display("FAIL full_last_border: got %0d writes want last addr FFFF of 65536", got_q.size()); end
    checks++; if (pix_cnt !== 17'd65536) begin errors++; $display("FAIL full_cnt: got %0d want 65536", pix_cnt); end
    checks++; if (mem_wen !== 1'b0 || overflow !== 1'b0)
      begin errors++; $display("FAIL full_idle: got wen=%b ovf=%b want 0/0", mem_wen, overflow); end
    sum = '0;
    foreach (exp_q[i]) sum = sum + 24'(exp_q[i][7:0]);
`ifdef BLFT_WB_CHECKSUM_EN
    checks++; if (chk_sum !== sum) begin errors++; $display("FAIL full_chk_sum: got %h want %h", chk_sum, sum); end
`endif
    tick();
    tick();
    checks++; if (pix_cnt !== 17'd65536 || done !== 1'b1)
      begin errors++; $display("FAIL full_hold: got cnt=%0d done=%b want 65536/1", pix_cnt, done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_random_ready();
    test_reset_border();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
